// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
// Shared definitions for the accumulator datapath:
//   - default widths for the accumulator and its operand counter
//   - acc_state_e : accumulator FSM states (IDLE, ACCUM, DONE)
//   - signed_ovf_bit : two's-complement overflow from the three adder MSBs
//   - carry_ovf_bit  : unsigned overflow / borrow from sub flag and carry-out
// ---------------------------------------------------------------------------
package arith_pkg;

   localparam int DEFAULT_DATA_WIDTH  = 32;
   localparam int DEFAULT_COUNT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } acc_state_e;

   // Overflow happens only when both adder inputs share a sign and the
   // result sign differs from it.
   function automatic logic signed_ovf_bit(input logic a_msb,
                                           input logic b_msb,
                                           input logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

   // Adding: a carry-out means the unsigned sum wrapped.
   // Subtracting (A + ~B + 1): a missing carry-out means a borrow.
   function automatic logic carry_ovf_bit(input logic sub,
                                          input logic carry_out);
      return sub ^ carry_out;
   endfunction

endpackage : arith_pkg

// File: rtl/accumulator_unit_if.sv
// ---------------------------------------------------------------------------
// accumulator_unit_if
// Control/data bundle between an accumulator client (master) and the
// accumulator_unit (slave).
//   master drives : start_i, length_i, operand_i, sub_i, operand_valid_i
//   slave drives  : ready_o, result_o, carry_ovf_o, signed_ovf_o, done_o,
//                   busy_o
// Signal names keep the _i/_o suffixes as seen from the accumulator.
// ---------------------------------------------------------------------------
interface accumulator_unit_if #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 8
);

   logic                   start_i;
   logic [COUNT_WIDTH-1:0] length_i;
   logic [DATA_WIDTH-1:0]  operand_i;
   logic                   sub_i;
   logic                   operand_valid_i;

   logic                   ready_o;
   logic [DATA_WIDTH-1:0]  result_o;
   logic                   carry_ovf_o;
   logic                   signed_ovf_o;
   logic                   done_o;
   logic                   busy_o;

   modport master (
      output start_i, length_i, operand_i, sub_i, operand_valid_i,
      input  ready_o, result_o, carry_ovf_o, signed_ovf_o, done_o, busy_o
   );

   modport slave (
      input  start_i, length_i, operand_i, sub_i, operand_valid_i,
      output ready_o, result_o, carry_ovf_o, signed_ovf_o, done_o, busy_o
   );

endinterface : accumulator_unit_if

// File: rtl/carry_lookahead_adder.sv
// ---------------------------------------------------------------------------
// carry_lookahead_adder
// Purely combinational WIDTH-bit adder built from 4-bit lookahead groups.
// Inside a group every carry is a flat function of the group carry-in;
// groups pass their carry to the next group via group generate/propagate.
//   operand_A_i, operand_B_i : addends
//   carry_i                  : carry into bit 0
//   result_o                 : sum modulo 2^WIDTH
//   carry_o                  : carry out of the MSB
// ---------------------------------------------------------------------------
module carry_lookahead_adder #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] operand_A_i,
   input  logic [WIDTH-1:0] operand_B_i,
   input  logic             carry_i,
   output logic [WIDTH-1:0] result_o,
   output logic             carry_o
);

   localparam int GROUPS    = (WIDTH + 3) / 4;
   localparam int PAD_WIDTH = GROUPS * 4;

   logic [PAD_WIDTH-1:0] gen;
   logic [PAD_WIDTH-1:0] prop;
   logic [GROUPS-1:0]    group_gen;
   logic [GROUPS-1:0]    group_prop;
   logic [PAD_WIDTH:0]   carry;

   genvar gi;

   // Per-bit generate/propagate; bits beyond WIDTH are tied off so that a
   // width that is not a multiple of four still maps onto whole groups.
   generate
      for (gi = 0; gi < PAD_WIDTH; gi++) begin : g_bit
         if (gi < WIDTH) begin : g_real
            assign gen[gi]  = operand_A_i[gi] & operand_B_i[gi];
            assign prop[gi] = operand_A_i[gi] ^ operand_B_i[gi];
         end else begin : g_pad
            assign gen[gi]  = 1'b0;
            assign prop[gi] = 1'b0;
         end
      end

      for (gi = 0; gi < GROUPS; gi++) begin : g_group
         assign group_gen[gi] = gen[4*gi+3]
                              | (prop[4*gi+3] & gen[4*gi+2])
                              | (prop[4*gi+3] & prop[4*gi+2] & gen[4*gi+1])
                              | (prop[4*gi+3] & prop[4*gi+2] & prop[4*gi+1] & gen[4*gi]);
         assign group_prop[gi] = &prop[4*gi +: 4];
      end
   endgenerate

   // Carry network: a local vector keeps the group-to-group dependency
   // inside one process.
   always_comb begin : carry_chain
      logic [PAD_WIDTH:0] c;
      c    = '0;
      c[0] = carry_i;
      for (int g = 0; g < GROUPS; g++) begin
         c[4*g+1] = gen[4*g]
                  | (prop[4*g] & c[4*g]);
         c[4*g+2] = gen[4*g+1]
                  | (prop[4*g+1] & gen[4*g])
                  | (prop[4*g+1] & prop[4*g] & c[4*g]);
         c[4*g+3] = gen[4*g+2]
                  | (prop[4*g+2] & gen[4*g+1])
                  | (prop[4*g+2] & prop[4*g+1] & gen[4*g])
                  | (prop[4*g+2] & prop[4*g+1] & prop[4*g] & c[4*g]);
         c[4*g+4] = group_gen[g] | (group_prop[g] & c[4*g]);
      end
      carry = c;
   end

   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sum
         assign result_o[gi] = prop[gi] ^ carry[gi];
      end
   endgenerate

   assign carry_o = carry[WIDTH];

endmodule : carry_lookahead_adder

// File: rtl/accumulator_unit.sv
// ---------------------------------------------------------------------------
// accumulator_unit
// Multi-operand add/subtract accumulator. A start latches the operand count
// and clears the sum and flags; each accepted operand is added to or
// subtracted from the running sum through a single carry_lookahead_adder.
// After the programmed count, done_o pulses for one cycle with the final
// sum and sticky unsigned/signed overflow flags on the outputs.
//   clk_i            : clock, rising edge
//   rst_i            : asynchronous active-high reset
//   bus.start_i      : begin a run (honoured in IDLE or DONE only)
//   bus.length_i     : operand count, sampled with start_i
//   bus.operand_i    : operand value
//   bus.sub_i        : 1 = subtract, 0 = add
//   bus.operand_valid_i : operand/sub qualifier
//   bus.ready_o      : operand accepted this cycle when valid
//   bus.result_o     : accumulator value
//   bus.carry_ovf_o  : sticky unsigned overflow/borrow
//   bus.signed_ovf_o : sticky two's-complement overflow
//   bus.done_o       : one-cycle completion pulse
//   bus.busy_o       : high while accepting operands
// ---------------------------------------------------------------------------
module accumulator_unit
   import arith_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
   input  logic              clk_i,
   input  logic              rst_i,
   accumulator_unit_if.slave bus
);

   acc_state_e             state_reg;
   logic [DATA_WIDTH-1:0]  acc_reg;
   logic [COUNT_WIDTH-1:0] count_reg;
   logic [COUNT_WIDTH-1:0] target_reg;
   logic                   carry_ovf_reg;
   logic                   signed_ovf_reg;
   logic                   done_reg;

   logic                   accum_active;
   logic                   xfer;
   logic [DATA_WIDTH-1:0]  add_b;
   logic [DATA_WIDTH-1:0]  add_sum;
   logic                   add_carry;
   logic [COUNT_WIDTH-1:0] count_next;
   logic                   carry_ovf_next;
   logic                   signed_ovf_next;

   // Accept decisions depend only on registered state, never on inputs.
   assign accum_active = (state_reg == ACCUM);
   assign xfer         = bus.operand_valid_i & accum_active;

   // Subtraction as A + ~B + 1: invert the operand and feed sub_i as the
   // carry-in.
   assign add_b = bus.sub_i ? ~bus.operand_i : bus.operand_i;

   carry_lookahead_adder #(
      .WIDTH (DATA_WIDTH)
   ) u_adder (
      .operand_A_i (acc_reg),
      .operand_B_i (add_b),
      .carry_i     (bus.sub_i),
      .result_o    (add_sum),
      .carry_o     (add_carry)
   );

   assign count_next      = count_reg + 1'b1;
   assign carry_ovf_next  = carry_ovf_reg
                          | carry_ovf_bit(bus.sub_i, add_carry);
   assign signed_ovf_next = signed_ovf_reg
                          | signed_ovf_bit(acc_reg[DATA_WIDTH-1],
                                           add_b[DATA_WIDTH-1],
                                           add_sum[DATA_WIDTH-1]);

   // FSM, accumulator, counter and sticky flags share one register block so
   // the done pulse is registered together with the state it reports.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg      <= IDLE;
         acc_reg        <= '0;
         count_reg      <= '0;
         target_reg     <= '0;
         carry_ovf_reg  <= 1'b0;
         signed_ovf_reg <= 1'b0;
         done_reg       <= 1'b0;
      end else begin
         case (state_reg)
            // DONE behaves like IDLE for a new start, which lets a client
            // chain runs without a dead cycle.
            IDLE, DONE: begin
               done_reg  <= 1'b0;
               state_reg <= IDLE;
               if (bus.start_i) begin
                  acc_reg        <= '0;
                  count_reg      <= '0;
                  carry_ovf_reg  <= 1'b0;
                  signed_ovf_reg <= 1'b0;
                  target_reg     <= bus.length_i;
                  if (bus.length_i == '0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg <= ACCUM;
                  end
               end
            end

            ACCUM: begin
               // Without a transfer every register holds (stall).
               if (xfer) begin
                  acc_reg        <= add_sum;
                  count_reg      <= count_next;
                  carry_ovf_reg  <= carry_ovf_next;
                  signed_ovf_reg <= signed_ovf_next;
                  if (count_next == target_reg) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end
               end
            end

            default: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready_o      = accum_active;
   assign bus.busy_o       = accum_active;
   assign bus.result_o     = acc_reg;
   assign bus.carry_ovf_o  = carry_ovf_reg;
   assign bus.signed_ovf_o = signed_ovf_reg;
   assign bus.done_o       = done_reg;

endmodule : accumulator_unit

// File: tb/tb_accumulator_unit.sv
// ---------------------------------------------------------------------------
// tb_accumulator_unit
// Directed and random stimulus for accumulator_unit. Expected results are
// computed by a modulo-2^32 reference model with sticky flags, pushed to a
// scoreboard queue when the operands are driven and popped when done_o
// is observed.
// ---------------------------------------------------------------------------
module tb_accumulator_unit;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   accumulator_unit_if #(.DATA_WIDTH(32), .COUNT_WIDTH(8)) bus ();

   accumulator_unit #(
      .DATA_WIDTH  (32),
      .COUNT_WIDTH (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        s;
   } exp_t;

   exp_t        sb[$];
   int          checks    = 0;
   int          errors    = 0;
   int          done_seen = 0;
   int          runs_done = 0;
   logic [31:0] op_a  [0:255];
   logic        sub_a [0:255];
   logic [31:0] last_result;

   // Independent count of done pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.done_o === 1'b1) done_seen++;
   end

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Run one accumulation starting at the current (post-edge) time; returns
   // during the DONE cycle so the caller can chain or idle.
   task automatic do_run(input int len, input int gap);
      logic [31:0] m_acc;
      logic        m_c;
      logic        m_s;
      longint      sr;
      logic [32:0] ur;
      int          k;
      exp_t        e;
      m_acc = '0;
      m_c   = 1'b0;
      m_s   = 1'b0;
      bus.start_i  = 1'b1;
      bus.length_i = 8'(len);
      if (len == 0) begin
         e.res = '0; e.c = 1'b0; e.s = 1'b0;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (len > 0) begin
         chk1 ("busy_after_start",  bus.busy_o,       1'b1);
         chk1 ("ready_after_start", bus.ready_o,      1'b1);
         chk1 ("done_after_start",  bus.done_o,       1'b0);
         chk32("result_cleared",    bus.result_o,     32'h0);
         chk1 ("carry_cleared",     bus.carry_ovf_o,  1'b0);
         chk1 ("signed_cleared",    bus.signed_ovf_o, 1'b0);
      end
      for (int i = 0; i < len; i++) begin
         bus.operand_valid_i = 1'b1;
         bus.operand_i       = op_a[i];
         bus.sub_i           = sub_a[i];
         if (sub_a[i]) begin
            if (op_a[i] > m_acc) m_c = 1'b1;
            sr    = longint'(int'(m_acc)) - longint'(int'(op_a[i]));
            m_acc = m_acc - op_a[i];
         end else begin
            ur = {1'b0, m_acc} + {1'b0, op_a[i]};
            if (ur > 33'h0_FFFF_FFFF) m_c = 1'b1;
            sr    = longint'(int'(m_acc)) + longint'(int'(op_a[i]));
            m_acc = m_acc + op_a[i];
         end
         if (sr > 64'sd2147483647 || sr < -64'sd2147483648) m_s = 1'b1;
         if (i == len - 1) begin
            e.res = m_acc; e.c = m_c; e.s = m_s;
            sb.push_back(e);
         end
         @(posedge clk); #1;
         bus.operand_valid_i = 1'b0;
         bus.sub_i           = $urandom_range(0, 1) == 1;
         bus.operand_i       = $urandom;
         if (i < len - 1) begin
            for (int g = 0; g < gap; g++) begin
               chk1("busy_in_gap", bus.busy_o, 1'b1);
               @(posedge clk); #1;
            end
         end
      end
      k = 0;
      while (bus.done_o !== 1'b1 && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      chk1 ("done_pulse",    bus.done_o,  1'b1);
      chk32("done_latency",  32'(k),      32'd0);
      chk1 ("ready_in_done", bus.ready_o, 1'b0);
      chk32("sb_depth",      32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk32("result",     bus.result_o,     e.res);
         chk1 ("carry_ovf",  bus.carry_ovf_o,  e.c);
         chk1 ("signed_ovf", bus.signed_ovf_o, e.s);
         last_result = e.res;
      end
      $display("run len=%0d gap=%0d result=%h carry=%b signed=%b",
               len, gap, bus.result_o, bus.carry_ovf_o, bus.signed_ovf_o);
      runs_done++;
   endtask

   initial begin
      int len;
      int gap;
      rst                 = 1'b1;
      bus.start_i         = 1'b0;
      bus.length_i        = '0;
      bus.operand_i       = '0;
      bus.sub_i           = 1'b0;
      bus.operand_valid_i = 1'b0;
      last_result         = '0;

      // Reset state, both while asserted and after release.
      #2;
      chk32("rst_result", bus.result_o,     32'h0);
      chk1 ("rst_carry",  bus.carry_ovf_o,  1'b0);
      chk1 ("rst_signed", bus.signed_ovf_o, 1'b0);
      chk1 ("rst_done",   bus.done_o,       1'b0);
      chk1 ("rst_ready",  bus.ready_o,      1'b0);
      chk1 ("rst_busy",   bus.busy_o,       1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk1 ("idle_busy",  bus.busy_o,       1'b0);

      // Adds 1..4 back-to-back.
      for (int i = 0; i < 4; i++) begin
         op_a[i]  = 32'(i + 1);
         sub_a[i] = 1'b0;
      end
      do_run(4, 0);

      // Reset in the middle of an accumulation (chained from DONE).
      bus.start_i  = 1'b1;
      bus.length_i = 8'd5;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      op_a[0] = 32'hFFFF_FFFF; op_a[1] = 32'hFFFF_FFFF; op_a[2] = 32'h5;
      for (int i = 0; i < 3; i++) begin
         bus.operand_valid_i = 1'b1;
         bus.operand_i       = op_a[i];
         bus.sub_i           = 1'b0;
         @(posedge clk); #1;
      end
      bus.operand_valid_i = 1'b0;
      chk32("pre_rst_result", bus.result_o,    32'h3);
      chk1 ("pre_rst_carry",  bus.carry_ovf_o, 1'b1);
      #3 rst = 1'b1;
      #1;
      chk32("async_rst_result", bus.result_o,    32'h0);
      chk1 ("async_rst_carry",  bus.carry_ovf_o, 1'b0);
      chk1 ("async_rst_busy",   bus.busy_o,      1'b0);
      chk1 ("async_rst_ready",  bus.ready_o,     1'b0);
      chk1 ("async_rst_done",   bus.done_o,      1'b0);
      @(posedge clk); #1;
      chk1 ("rst_hold_done",    bus.done_o,      1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk1 ("post_rst_busy",    bus.busy_o,      1'b0);
      chk1 ("post_rst_done",    bus.done_o,      1'b0);

      // add 5, sub 7 -> borrow, then a chained start in the DONE cycle:
      // 0x7FFFFFFF + 1 -> signed overflow with the old borrow flag cleared.
      op_a[0] = 32'd5; sub_a[0] = 1'b0;
      op_a[1] = 32'd7; sub_a[1] = 1'b1;
      do_run(2, 0);
      op_a[0] = 32'h7FFF_FFFF; sub_a[0] = 1'b0;
      op_a[1] = 32'h1;         sub_a[1] = 1'b0;
      do_run(2, 0);

      // operand_valid_i pulses while IDLE must not touch the result.
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
         bus.operand_valid_i = 1'b1;
         bus.operand_i       = 32'h1234_5678;
         bus.sub_i           = 1'b0;
         @(posedge clk); #1;
         chk32("idle_valid_result", bus.result_o, last_result);
         chk1 ("idle_valid_busy",   bus.busy_o,   1'b0);
      end
      bus.operand_valid_i = 1'b0;

      // Three operands with two-cycle gaps.
      op_a[0] = 32'd100; sub_a[0] = 1'b0;
      op_a[1] = 32'd250; sub_a[1] = 1'b0;
      op_a[2] = 32'd30;  sub_a[2] = 1'b1;
      do_run(3, 2);
      @(posedge clk); #1;

      // Zero-length run.
      do_run(0, 0);
      @(posedge clk); #1;

      // Random regression, randomly chained or separated by an idle cycle.
      for (int r = 0; r < 1000; r++) begin
         len = $urandom_range(0, 10);
         gap = $urandom_range(0, 1);
         for (int i = 0; i < len; i++) begin
            op_a[i]  = $urandom;
            sub_a[i] = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
               0: op_a[i] = 32'h7FFF_FFFF;
               1: op_a[i] = 32'h8000_0000;
               default: ;
            endcase
         end
         do_run(len, gap);
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
         end
      end

      @(posedge clk); #1;
      @(posedge clk); #1;
      chk32("done_pulse_count", 32'(done_seen), 32'(runs_done));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_accumulator_unit
